// File: rtl/baud_gen_frac_pkg.sv
// Shared constants for the fractional baud generator: reset divisor, minimum legal
// divisor and the oversample-phase width helper.
package baud_pkg;

  localparam int RESET_DIV  = 20;
  localparam int RESET_FRAC = 0;
  localparam int MIN_DIV    = 2;

  function automatic int phase_w(input int os_rate);
    return (os_rate > 2) ? $clog2(os_rate) : 1;
  endfunction

endpackage

// File: rtl/baud_gen_frac_accum.sv
// Fractional-divisor accumulator: adds frac on each strobe, holds the carry that
// stretches the following period by one cycle. clr wins over add.
module frac_accum #(
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              add,
  input  logic [FRAC_W-1:0] frac,
  output logic              carry
);

  logic [FRAC_W-1:0] acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      carry <= 1'b0;
    end else if (clr) begin
      acc   <= '0;
      carry <= 1'b0;
    end else if (add) begin
      {carry, acc} <= {1'b0, acc} + {1'b0, frac};
    end
  end

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional baud generator: registered oversample and bit ticks, runtime divisor
// staged and applied on an os_tick boundary (or immediately by restart).
module baud_gen_frac
  import baud_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 4,
  parameter int OS_RATE    = 16,
  parameter int RESET_DIV  = baud_pkg::RESET_DIV,
  parameter int RESET_FRAC = baud_pkg::RESET_FRAC
) (
  input  logic                           sys_clk,
  input  logic                           reset_n,
  input  logic                           en,
  input  logic [DIV_W-1:0]               div_int,
  input  logic [FRAC_W-1:0]              div_frac,
  input  logic                           div_load,
  input  logic                           restart,
  output logic                           os_tick,
  output logic                           bit_tick,
  output logic [phase_w(OS_RATE)-1:0]    os_phase,
  output logic                           div_ack,
  output logic                           cfg_err
);

  localparam int PH_W = phase_w(OS_RATE);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0] MIN_V   = DIV_W'(MIN_DIV);
  localparam logic [PH_W-1:0]  PH_ONE  = PH_W'(1);
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(OS_RATE - 1);

  logic [DIV_W-1:0]  cnt, act_int, stg_int, sel_int, app_int;
  logic [FRAC_W-1:0] act_frac, stg_frac, sel_frac, add_frac;
  logic              pending, carry, period_end, tick, apply, direct;

  // A restart coinciding with div_load bypasses staging and applies the inputs directly.
  always_comb begin
    direct     = restart && div_load;
    sel_int    = direct ? div_int : stg_int;
    sel_frac   = direct ? div_frac : stg_frac;
    app_int    = (sel_int < MIN_V) ? MIN_V : sel_int;
    period_end = en && (cnt == (carry ? act_int : act_int - ONE));
    tick       = period_end && !restart;
    apply      = (tick && pending) || (restart && (pending || div_load));
    add_frac   = (tick && pending) ? stg_frac : act_frac;
  end

  frac_accum #(.FRAC_W(FRAC_W)) u_accum (
    .clk   (sys_clk),
    .rst_n (reset_n),
    .clr   (restart),
    .add   (tick),
    .frac  (add_frac),
    .carry (carry)
  );

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      os_phase <= '0;
      act_int  <= DIV_W'(RESET_DIV);
      act_frac <= FRAC_W'(RESET_FRAC);
      stg_int  <= '0;
      stg_frac <= '0;
      pending  <= 1'b0;
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
      div_ack  <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      os_tick  <= tick;
      bit_tick <= tick && (os_phase == PH_LAST);
      div_ack  <= apply;
      if (restart) begin
        cnt      <= '0;
        os_phase <= '0;
      end else if (period_end) begin
        cnt      <= '0;
        os_phase <= os_phase + PH_ONE;
      end else if (en) begin
        cnt <= cnt + ONE;
      end
      if (apply) begin
        act_int  <= app_int;
        act_frac <= sel_frac;
        cfg_err  <= (sel_int < MIN_V);
        pending  <= 1'b0;
      end
      // A load in the same cycle as an apply re-arms staging for the next boundary.
      if (div_load && !restart) begin
        stg_int  <= div_int;
        stg_frac <= div_frac;
        pending  <= 1'b1;
      end
    end
  end

endmodule
